// File: rtl/reg_dump_streamer_pkg.sv
// reg_dump_streamer_pkg: shared debug-reader types, ASCII constants and register-bus indexing
// Contents: RV32_Regs_t debug bus (element i is register xi), dump_state_t,
//           DUMP_LINE_LEN, ASCII constants, get_reg() bus indexer
package pcpu;
    typedef logic [31:0][31:0] RV32_Regs_t;
    typedef enum logic [1:0] {IDLE, EMIT, DONE} dump_state_t;
    localparam int DUMP_LINE_LEN = 13;
    localparam logic [7:0] CH_X  = 8'h78;
    localparam logic [7:0] CH_EQ = 8'h3D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_A  = 8'h41;
    function automatic logic [31:0] get_reg(input RV32_Regs_t regs, input logic [4:0] num);
        return regs[num];
    endfunction
endpackage

// File: rtl/reg_dump_streamer_if.sv
// reg_dump_if: byte stream with valid/ready handshake
// Signals: tx_data (ASCII byte), tx_valid (byte offered), tx_ready (sink accepts)
// Modports: master drives data/valid, slave drives ready
interface reg_dump_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/reg_dump_streamer_fmt.sv
// reg_dump_fmt: character at position i_pos of the text line "xNN=HHHHHHHH\n" for one register
// Ports: i_value register value, i_idx register number, i_pos column 0..12, o_char ASCII byte
module reg_dump_fmt
    import pcpu::*;
#(
    parameter bit UPPER_HEX = 1
) (
    input  logic [31:0] i_value,
    input  logic [4:0]  i_idx,
    input  logic [3:0]  i_pos,
    output logic [7:0]  o_char
);
    logic [3:0] w_tens, w_ones, w_nib;
    logic [4:0] w_base;
    logic [7:0] w_hex_a, w_hex;
    assign w_tens  = i_idx >= 5'd30 ? 4'd3 : i_idx >= 5'd20 ? 4'd2 : i_idx >= 5'd10 ? 4'd1 : 4'd0;
    assign w_base  = i_idx >= 5'd30 ? 5'd30 : i_idx >= 5'd20 ? 5'd20 : i_idx >= 5'd10 ? 5'd10 : 5'd0;
    assign w_ones  = 4'(i_idx - w_base);
    // columns 4..11 carry nibbles 7..0, so the shift is (11 - pos) nibbles
    assign w_nib   = 4'(i_value >> {3'(4'd11 - i_pos), 2'b00});
    assign w_hex_a = UPPER_HEX ? CH_A : (CH_A | 8'h20);
    assign w_hex   = w_nib < 4'd10 ? CH_0 + 8'(w_nib) : w_hex_a + 8'(w_nib) - 8'd10;
    assign o_char  = i_pos == 4'd0 ? CH_X :
                     i_pos == 4'd1 ? CH_0 + 8'(w_tens) :
                     i_pos == 4'd2 ? CH_0 + 8'(w_ones) :
                     i_pos == 4'd3 ? CH_EQ :
                     i_pos == 4'(DUMP_LINE_LEN - 1) ? CH_LF : w_hex;
endmodule

// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer: snapshot the RV32 register file and stream it as ASCII text lines
// Ports: clk, rst (async, active-high); regs_in live debug bus; start/abort control;
//        tx byte stream (master modport); busy, done (1-cycle pulse), reg_idx progress
module reg_dump_streamer
    import pcpu::*;
#(
    parameter int NUM_REGS  = 32,
    parameter bit UPPER_HEX = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  RV32_Regs_t  regs_in,
    input  logic        start,
    input  logic        abort,
    reg_dump_if.master  tx,
    output logic        busy,
    output logic        done,
    output logic [4:0]  reg_idx
);
    dump_state_t r_state;
    RV32_Regs_t  r_snap, w_snap;
    logic [4:0]  r_idx, w_nidx;
    logic [3:0]  r_pos, w_npos;
    logic [7:0]  r_data, w_char;
    logic [31:0] w_val;
    logic        r_valid, r_busy, r_done, w_xfer, w_eol, w_end;
    // x0 is hardwired zero, so it is cleared as it enters the snapshot
    always_comb begin
        w_snap    = regs_in;
        w_snap[0] = '0;
    end
    assign w_xfer = r_valid && tx.tx_ready;
    assign w_eol  = r_pos == 4'(DUMP_LINE_LEN - 1);
    assign w_end  = w_eol && r_idx == 5'(NUM_REGS - 1);
    // coordinates of the byte to present after this edge; (0,0) when leaving IDLE
    assign w_npos = (r_state == EMIT && !w_eol) ? r_pos + 4'd1 : 4'd0;
    assign w_nidx = r_state != EMIT ? 5'd0 : w_eol ? r_idx + 5'd1 : r_idx;
    assign w_val  = get_reg(r_snap, w_nidx);
    reg_dump_fmt #(.UPPER_HEX(UPPER_HEX)) u_fmt (
        .i_value(w_val),
        .i_idx  (w_nidx),
        .i_pos  (w_npos),
        .o_char (w_char)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_snap  <= '0;
            r_idx   <= '0;
            r_pos   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start && !abort) begin
                    r_snap  <= w_snap;
                    r_idx   <= '0;
                    r_pos   <= '0;
                    r_data  <= w_char;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= EMIT;
                end
                EMIT: if (abort) begin
                    r_idx   <= '0;
                    r_pos   <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end else if (w_xfer) begin
                    if (w_end) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx  <= w_nidx;
                        r_pos  <= w_npos;
                        r_data <= w_char;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign tx.tx_data  = r_data;
    assign tx.tx_valid = r_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign reg_idx     = r_idx;
endmodule

// File: tb/tb_reg_dump_streamer.sv
// tb_reg_dump_streamer: scoreboard bench for the register dump streamer
module tb_reg_dump_streamer;
    import pcpu::*;
    logic clk = 0, rst = 1, start = 0, abort = 0, start2 = 0;
    logic busy, done, busy2, done2;
    logic [4:0] reg_idx, reg_idx2;
    RV32_Regs_t regs = '0;
    int checks = 0, errors = 0, nbytes = 0, ndone = 0, cyc = 0;
    logic [7:0] exp_q[$], cap[$], cap2[$];
    logic stall_prev = 0;
    logic [7:0] prev_data = 0;
    logic [7:0] a0_line [13] = '{8'h78, 8'h31, 8'h30, 8'h3D, 8'h44, 8'h45, 8'h41,
                                 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0A};
    string s0 = "x00=00000000\n", s2 = "x02=00001000\n", s31 = "x31=abcdef01\n";

    reg_dump_if tx();
    reg_dump_if tx2();
    assign tx2.tx_ready = 1'b1;

    always #5 clk = ~clk;

    reg_dump_streamer #(.NUM_REGS(32), .UPPER_HEX(1)) dut (
        .clk(clk), .rst(rst), .regs_in(regs), .start(start), .abort(abort),
        .tx(tx), .busy(busy), .done(done), .reg_idx(reg_idx));
    reg_dump_streamer #(.NUM_REGS(32), .UPPER_HEX(0)) dut_lc (
        .clk(clk), .rst(rst), .regs_in(regs), .start(start2), .abort(1'b0),
        .tx(tx2), .busy(busy2), .done(done2), .reg_idx(reg_idx2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hx(input logic [3:0] n, input bit up);
        return (n < 4'd10) ? 8'h30 + 8'(n) : (up ? 8'h41 : 8'h61) + 8'(n) - 8'd10;
    endfunction

    function automatic logic [7:0] line_byte(input RV32_Regs_t r, input int i, input int j, input bit up);
        logic [31:0] v;
        v = (i == 0) ? 32'h0 : r[5'(i)];
        case (j)
            0: return 8'h78;
            1: return 8'h30 + 8'(i / 10);
            2: return 8'h30 + 8'(i % 10);
            3: return 8'h3D;
            12: return 8'h0A;
            default: return hx(v[(11 - j) * 4 +: 4], up);
        endcase
    endfunction

    task automatic push_dump();
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 13; j++) exp_q.push_back(line_byte(regs, i, j, 1'b1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready held high; 1: backpressure; 2: stray start pulse at byte 50
    task automatic run(input int mode, output int n);
        n = 0;
        while (!done && n < 5000) begin
            if (mode == 1) tx.tx_ready = (n < 4) ? (n == 0 || n == 3) : 1'($urandom_range(0, 1));
            start = (mode == 2 && nbytes == 50);
            tick();
            n++;
        end
        start = 0;
        tx.tx_ready = 1;
        chk("done_seen", done, 1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev && tx.tx_valid) chk("stall_hold", tx.tx_data, prev_data);
            if (tx.tx_valid && tx.tx_ready && !abort) begin
                if (exp_q.size() == 0) chk("extra_byte", 1, 0);
                else chk($sformatf("byte%0d", nbytes), tx.tx_data, exp_q.pop_front());
                cap.push_back(tx.tx_data);
                nbytes++;
            end
            stall_prev = tx.tx_valid && !tx.tx_ready && !abort;
            prev_data  = tx.tx_data;
            if (done) ndone++;
            if (tx2.tx_valid && tx2.tx_ready) cap2.push_back(tx2.tx_data);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tx.tx_ready = 1;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0101 * i + 32'h10;
        regs[0]  = 32'h1234_5678;
        regs[10] = 32'hDEAD_BEEF;
        repeat (2) tick();
        rst = 0;
        tick();
        chk("rst_valid", tx.tx_valid, 0);
        chk("rst_data", tx.tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", reg_idx, 0);

        push_dump();
        start = 1;
        tick();
        start = 0;
        chk("lat_valid", tx.tx_valid, 1);
        chk("lat_x", tx.tx_data, 8'h78);
        chk("lat_busy", busy, 1);
        run(0, cyc);
        chk("lat_cycles", cyc, 416);
        chk("done_busy", busy, 0);
        chk("done_valid", tx.tx_valid, 0);
        tick();
        chk("done_one_cycle", done, 0);
        chk("bytes_total", nbytes, 416);
        chk("done_count", ndone, 1);
        chk("queue_empty", exp_q.size(), 0);
        for (int j = 0; j < 13; j++) chk($sformatf("a0_line%0d", j), cap[130 + j], a0_line[j]);
        for (int j = 0; j < 13; j++) chk($sformatf("x0_line%0d", j), cap[j], s0[j]);

        nbytes = 0; ndone = 0; cap.delete();
        push_dump();
        start = 1;
        tick();
        start = 0;
        run(1, cyc);
        tick();
        chk("bp_bytes", nbytes, 416);
        chk("bp_done", ndone, 1);
        chk("bp_queue_empty", exp_q.size(), 0);

        nbytes = 0; ndone = 0; cap.delete();
        regs[2] = 32'h0000_1000;
        push_dump();
        start = 1;
        tick();
        start = 0;
        regs[2] = 32'hFFFF_FFFF;
        run(0, cyc);
        tick();
        for (int j = 0; j < 13; j++) chk($sformatf("snap_line%0d", j), cap[26 + j], s2[j]);

        nbytes = 0; ndone = 0; cap.delete();
        push_dump();
        start = 1;
        tick();
        start = 0;
        run(2, cyc);
        start = 1;
        tick();
        chk("start_in_done_ignored", tx.tx_valid, 0);
        chk("stray_bytes", nbytes, 416);
        chk("stray_done", ndone, 1);
        nbytes = 0;
        push_dump();
        tick();
        start = 0;
        chk("restart_valid", tx.tx_valid, 1);
        chk("restart_x", tx.tx_data, 8'h78);

        cyc = 0;
        while (nbytes < 200 && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk("abort_reach", nbytes, 200);
        abort = 1;
        tick();
        abort = 0;
        exp_q.delete();
        chk("abort_valid", tx.tx_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_discard", nbytes, 200);
        ndone = 0;
        repeat (3) tick();
        chk("abort_no_done", ndone, 0);
        start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        chk("abort_over_start", tx.tx_valid, 0);
        nbytes = 0; cap.delete();
        push_dump();
        start = 1;
        tick();
        start = 0;
        chk("post_abort_x", tx.tx_data, 8'h78);
        chk("post_abort_idx", reg_idx, 0);
        run(0, cyc);
        tick();
        chk("post_abort_bytes", nbytes, 416);
        chk("post_abort_queue", exp_q.size(), 0);

        push_dump();
        start = 1;
        tick();
        start = 0;
        repeat (20) tick();
        #2 rst = 1;
        #1;
        chk("arst_valid", tx.tx_valid, 0);
        chk("arst_data", tx.tx_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_idx", reg_idx, 0);
        exp_q.delete();
        repeat (2) tick();
        rst = 0;
        repeat (3) tick();
        chk("arst_stays_idle", tx.tx_valid, 0);

        regs[31] = 32'hABCD_EF01;
        start2 = 1;
        tick();
        start2 = 0;
        cyc = 0;
        while (!done2 && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk("lc_done", done2, 1);
        tick();
        chk("lc_bytes", cap2.size(), 416);
        if (cap2.size() == 416) begin
            for (int j = 0; j < 13; j++) chk($sformatf("lc_t6_%0d", j), cap2[403 + j], s31[j]);
            for (int k = 0; k < 416; k++) chk($sformatf("lc_byte%0d", k), cap2[k], line_byte(regs, k / 13, k % 13, 1'b0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_dump_streamer.md
Name: reg_dump_streamer

Overview:
Debug reader for the architectural register file. On a start request it snapshots all 32 RV32 registers from the RV32_Regs_t debug bus and serialises them as ASCII text over a byte stream with a valid/ready handshake. The stream feeds the debug UART transmitter or the VGA text console. It sits beside the register file on the same debug bus used by the VGA register display.

Parameters:
NUM_REGS, 32, number of registers dumped, x0 first; legal range 1..32
UPPER_HEX, 1, 1 selects hex digits 'A'-'F', 0 selects 'a'-'f'

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  reset, asynchronous, active-high
regs_in  input  RV32_Regs_t (1024)  live register-file debug bus (x0..t6)
start  input  1  request a dump; sampled every cycle
abort  input  1  cancel the dump in progress
tx_data  output  8  ASCII byte
tx_valid  output  1  tx_data is valid
tx_ready  input  1  sink accepts the byte
busy  output  1  dump in progress
done  output  1  one-cycle pulse after the last byte is accepted
reg_idx  output  5  index of the register being emitted

Behaviour:
- Reset (async, active-high) forces:
  - state to IDLE;
  - tx_data, tx_valid, busy, done and reg_idx to 0;
  - the snapshot register to 0.
- Line format per register i, 13 bytes:
  - 'x' (0x78), then two decimal digits of i, tens first;
  - '=' (0x3D);
  - 8 hex digits of the value, MSB nibble first;
  - '\n' (0x0A).
- Total dump length is NUM_REGS*13 bytes (416 at the default).
- Decimal digits come from compares (i>=30, >=20, >=10), not a divider.
- Handshake:
  - A transfer occurs on a posedge where tx_valid && tx_ready.
  - While tx_valid=1 and no transfer has occurred, tx_data is held stable.
  - The only exceptions are abort and rst.
- States:
  - IDLE: busy=0, tx_valid=0. start=1 latches regs_in into the snapshot, sets reg_idx=0 and char_pos=0, and moves to EMIT.
  - EMIT: busy=1, tx_valid=1, tx_data=fmt(snapshot[reg_idx], reg_idx, char_pos). On a transfer:
    - char_pos increments.
    - At char_pos=12 it wraps to 0 and reg_idx increments.
    - On the transfer of char_pos=12 with reg_idx=NUM_REGS-1, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency:
  - start accepted at edge t gives tx_valid=1 with 'x' after edge t.
  - With tx_ready held 1, one byte per cycle.
  - done is high in the cycle after the final transfer edge.
- Snapshot: regs_in changes after the start edge do not affect the output. x0 always prints 00000000.
- start while busy, or in the DONE cycle, is ignored; no queuing.
- Abort:
  - In EMIT, abort goes to IDLE at the next edge.
  - tx_valid drops with no done pulse, and any transfer at that edge is discarded.
  - Abort has priority over the transfer.
  - In IDLE, abort has priority over start.
- reg_idx never exceeds NUM_REGS-1, and char_pos never exceeds 12.
- rst mid-dump returns to IDLE immediately; no further bytes are emitted.

Decomposition:
- Shared package pcpu:
  - ASCII constants (CH_X, CH_EQ, CH_LF, CH_0, CH_A).
  - dump_state_t enum {IDLE, EMIT, DONE}.
  - DUMP_LINE_LEN = 13.
- Add to pcpu a function indexing RV32_Regs_t by 5-bit number; it is shared with future debug readers.
- One sub-module, reg_dump_fmt: combinational (value[31:0], idx[4:0], pos[3:0]) -> char[7:0]. It contains the nibble-to-ASCII and decimal-digit logic, parameterised by UPPER_HEX.

Test Plan:
- Reset, then start with a0 (x10)=32'hDEADBEEF and tx_ready=1:
  - Bytes 130..142 are 78 31 30 3D 44 45 41 44 42 45 45 46 0A.
  - Bytes 0..12 are "x00=00000000\n".
  - 416 bytes total, then done high for 1 cycle, then busy=0.
- Backpressure: tx_ready toggles 1,0,0,1 with a random pattern. tx_data must be stable across stalls, the byte sequence must be identical to the tx_ready=1 run, and there are no dropped or duplicated bytes.
- Snapshot: set sp=32'h0000_1000, start, then set sp=32'hFFFF_FFFF on the next cycle. The x02 line still reads "x02=00001000".
- start pulsed during EMIT at byte 50: ignored, with exactly 416 bytes and one done. start in IDLE the cycle after done begins a new dump.
- abort at byte 200:
  - tx_valid=0 and busy=0 after the next edge, with no done pulse.
  - A following start restarts at byte 'x' of x00.
- rst asserted asynchronously mid-byte with tx_valid=1: all outputs 0 immediately. With UPPER_HEX=0, t6=32'hABCDEF01 prints "x31=abcdef01\n".
